// File: rtl/datapath_pkg.sv
// datapath_pkg: shared widths and framer state encoding for the ALU datapath slice.
package datapath_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int CSUM_WIDTH = DATA_WIDTH;
  typedef enum logic {DATA, CSUM} frame_state_t;
endpackage

// File: rtl/datapath_sync_fifo.sv
// datapath_sync_fifo: first-word fall-through FIFO with registered occupancy.
module datapath_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/datapath_result_framer.sv
// datapath_result_framer: buffers datapath results and emits them in frames,
// each closed by a checksum word flagged with out_last.
module datapath_result_framer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int FRAME_LEN = 4,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
  output logic                      overflow
);
  import datapath_pkg::*;
  localparam int CW = $clog2(FRAME_LEN) + 1;
  frame_state_t state;
  logic [DATA_WIDTH-1:0] head, checksum;
  logic [CW-1:0] word_cnt;
  logic full, empty, xfer, pop;
  datapath_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_valid),
    .wdata(in_data),
    .pop(pop),
    .rdata(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  assign out_valid = state == CSUM || !empty;
  assign out_last = state == CSUM;
  assign out_data = state == CSUM ? checksum : empty ? '0 : head;
  assign xfer = out_valid && out_ready;
  assign pop = xfer && state == DATA;
  // full is the registered level, so a same-cycle pop never rescues an incoming word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DATA;
      checksum <= '0;
      word_cnt <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_valid && full) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
      end
      if (pop) begin
        checksum <= checksum + head;
        word_cnt <= word_cnt + CW'(1);
        if (word_cnt == CW'(FRAME_LEN - 1)) state <= CSUM;
      end else if (xfer) begin
        checksum <= '0;
        word_cnt <= '0;
        state <= DATA;
      end
    end
  end
endmodule

// File: doc/datapath_result_framer.md
Name: datapath_result_framer

Overview:
- Downstream stage of the ALU datapath host. Consumes its 16-bit `result_out`/`valid_out` stream and buffers results in a small FIFO.
- Emits results on a ready/valid output stream, grouped into frames of FRAME_LEN data words. Each frame is followed by one inserted checksum word flagged with `out_last`.
- Counts results dropped while the buffer is full, so downstream backpressure is visible.

Parameters:
- DATA_WIDTH, 16, width of result words and checksum.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- FRAME_LEN, 4, data words per frame before checksum insertion; at least 1.
- DROP_CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- in_data  input  DATA_WIDTH  result word from the datapath host.
- in_valid  input  1  in_data is valid this cycle; no backpressure toward the host.
- out_data  output  DATA_WIDTH  data word or checksum word.
- out_valid  output  1  out_data is valid.
- out_last  output  1  high only while a checksum word is presented.
- out_ready  input  1  consumer accepts the word this cycle.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- drop_cnt  output  DROP_CNT_WIDTH  saturating count of dropped inputs.
- overflow  output  1  sticky; set on the first drop, cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous): pointers, fifo_level, checksum, word_cnt, drop_cnt and overflow all go to 0; FSM enters DATA; out_valid=0, out_last=0, out_data=0.
- Push: on in_valid=1 with registered fifo_level<DEPTH, write in_data at wr_ptr; wr_ptr wraps modulo DEPTH.
- Drop: on in_valid=1 with fifo_level==DEPTH, discard the word, increment drop_cnt (saturating at all-ones) and set overflow.
  - A same-cycle pop does not rescue the word; full is judged on the pre-edge level.
- Transfer: a transfer occurs when out_valid=1 and out_ready=1.
- FSM state DATA:
  - out_valid = (fifo_level!=0); out_data = head entry (first-word fall-through); out_last=0.
  - On transfer: pop, checksum <= checksum + out_data (mod 2^DATA_WIDTH), word_cnt++.
  - If word_cnt==FRAME_LEN-1 at that transfer, go to CSUM.
  - When empty, out_data is 0.
- FSM state CSUM:
  - out_valid=1, out_last=1, out_data=checksum; these stay stable while out_ready=0.
  - Pushes continue normally; no pop.
  - On transfer: checksum<=0, word_cnt<=0, go to DATA.
- Latency: a word pushed at edge n appears on out_data with out_valid=1 after edge n (the cycle following the push), provided it is at the FIFO head and the FSM is in DATA.
- Simultaneous push and pop in DATA (not full): fifo_level is unchanged and both pointers advance.
- out_data/out_valid must not depend combinationally on in_valid or in_data.
- out_valid may depend only on state and fifo_level; out_ready affects state only at the clock edge.
- Reset mid-frame discards buffered data and the partial checksum; the next frame starts at word_cnt=0.
- fifo_level never exceeds DEPTH and never underflows.

Decomposition:
- Shared package datapath_pkg:
  - DATA_WIDTH constant.
  - Framer FSM state enum (DATA, CSUM).
  - Checksum width constant.
- One sub-module, datapath_sync_fifo:
  - Parameterised DEPTH/width, first-word fall-through.
  - Interface: push, pop, full, empty, level.
  - Uses the same clk and active-low asynchronous rst.
- The framer FSM, checksum and drop logic live in the top module.

Test Plan:
- Frame with no backpressure (FRAME_LEN=4, out_ready=1): push 0x0001,0x0002,0x0003,0x0004 → out 1,2,3,4, then 0x000A with out_last=1; drop_cnt=0.
- Overflow: out_ready=0, push 10 consecutive words → fifo_level=8, drop_cnt=2, overflow=1; then out_ready=1 → first 8 words emerge in order plus checksums.
- Checksum backpressure: hold out_ready=0 for 5 cycles while in CSUM → out_data=0x000A, out_valid=1, out_last=1 stable; pushes still raise fifo_level.
- Checksum wrap: frame 0xFFFF,0x0002,0x0000,0x0000 → checksum word 0x0001.
- Reset mid-frame: after 2 of 4 words transferred, pulse rst=0 for one cycle → all outputs 0; next frame 5,5,5,5 → checksum 0x0014.
- Drop saturation: out_ready=0, fill the FIFO, then 300 further pushes → drop_cnt=255 and held; overflow=1.
